multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Multi-cycle sequencer for the 32b core's shared-memory datapath. Same ISA and
//  ALUOperation/RegDst/PCSrc encodings as the single-cycle decoder. A Moore FSM
//  steps each instruction through FETCH/DECODE/EXEC/MEM/WB, stalling on a
//  memory ready handshake. Sits between IR/Zero and the datapath muxes/enables.
// PARAMETERS
//  CNT_W        32   width of retired-instruction counter
//  MEM_TIMEOUT  255  max stall cycles on one memory access before MemErr (>=1)
// PORTS
//  clk           in   1  clock, all state on rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  OpCode        in   6  IR[31:26], valid from DECODE onward
//  Func          in   6  IR[5:0]
//  Zero          in   1  ALU zero flag, sampled in BRANCH
//  MemReady      in   1  memory completes current access this cycle
//  IorD          out  1  0: address=PC, 1: address=ALUOut
//  MemRead       out  1  memory read request, held until MemReady
//  MemWrite      out  1  memory write request, held until MemReady
//  IRWrite       out  1  load IR from memory data
//  PCWrite       out  1  load PC
//  PCSrc         out  2  00 ALU, 01 branch target(ALUOut), 10 jump, 11 register(jr)
//  ALUSrcA       out  1  0: PC, 1: reg A
//  ALUSrcB       out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALUOperation  out  3  000 add,001 sub,010 and,011 or,100 slt
//  RegWrite      out  1  register file write enable
//  RegDst        out  2  00 rt, 01 rd, 10 r31
//  RegWSrc       out  1  1: ALUOut/MDR, 0: PC (jal link)
//  MemToReg      out  1  1: MDR, 0: ALUOut
//  Retired       out  CNT_W  instructions completed since reset, wraps
//  MemErr        out  1  sticky: memory access exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0, any cycle, incl. mid-access): state=IDLE, Retired=0,
//   MemErr=0, wait counter=0; every output 0. IDLE -> FETCH next cycle.
//  Outputs are decoded from state only, except PCWrite/IRWrite (qualified by
//   MemReady in FETCH) and PCWrite in BRANCH (=Zero). Unlisted outputs are 0.
//  FETCH: IorD=0,MemRead=1,ALUSrcA=0,ALUSrcB=01,op=add,PCSrc=00. Stay until
//   MemReady; on MemReady: IRWrite=1,PCWrite=1 -> DECODE.
//  DECODE: ALUSrcA=0,ALUSrcB=11,op=add (branch target). Next by OpCode:
//   0 -> EXEC_R (legal Func 000001/000010/000100/001000/010000, else ILLEGAL)
//   1,2 -> EXEC_I; 3,4 -> MEM_ADDR; 5 -> BRANCH; 6 -> JUMP; 7 -> JR;
//   8 -> JAL; other -> ILLEGAL.
//  EXEC_R: ALUSrcA=1,ALUSrcB=00,op by Func (add,sub,and,or,slt) -> WB_R.
//  WB_R: RegWrite=1,RegDst=01,RegWSrc=1,MemToReg=0 -> FETCH (retire).
//  EXEC_I: ALUSrcA=1,ALUSrcB=10,op=add(1)/slt(2) -> WB_I.
//  WB_I: RegWrite=1,RegDst=00,RegWSrc=1,MemToReg=0 -> FETCH (retire).
//  MEM_ADDR: ALUSrcA=1,ALUSrcB=10,op=add -> MEM_RD (3) / MEM_WR (4).
//  MEM_RD: IorD=1,MemRead=1; wait MemReady -> MEM_WB.
//  MEM_WB: RegWrite=1,RegDst=00,RegWSrc=1,MemToReg=1 -> FETCH (retire).
//  MEM_WR: IorD=1,MemWrite=1; wait MemReady -> FETCH (retire on MemReady).
//  BRANCH: ALUSrcA=1,ALUSrcB=00,op=sub,PCSrc=01,PCWrite=Zero -> FETCH (retire).
//  JUMP: PCWrite=1,PCSrc=10 -> FETCH. JR: PCWrite=1,PCSrc=11 -> FETCH.
//  JAL: PCWrite=1,PCSrc=10,RegWrite=1,RegDst=10,RegWSrc=0 -> FETCH. All retire.
//  Retired increments by 1 on the cycle leaving a retiring state; 2^CNT_W-1 -> 0.
//  Wait counter: clears on entry to FETCH/MEM_RD/MEM_WR, +1 per stalled cycle;
//   when it reaches MEM_TIMEOUT with MemReady=0: MemErr<=1, state -> IDLE
//   (access abandoned, instruction not retired). MemErr cleared only by reset.
//  MemReady outside FETCH/MEM_RD/MEM_WR is ignored.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: ILLEGAL state is terminal, all outputs 0, extra port
//   Illegal out 1 = 1 while in ILLEGAL; exit only by reset; not retired.
//  Undefined: ILLEGAL is one NOP cycle -> FETCH, retired; no Illegal port.
// TESTING
//  add (Op0,Func000001), MemReady=1 always -> FETCH,DECODE,EXEC_R,WB_R; op=000, Retired=1.
//  lw (Op3), MemReady low 3 cycles in MEM_RD -> MemRead held 4 cycles, MemToReg=1 in MEM_WB.
//  beq (Op5) Zero=1 -> PCWrite=1,PCSrc=01; Zero=0 -> PCWrite=0; both retire.
//  jal (Op8) -> PCWrite=1,PCSrc=10,RegWrite=1,RegDst=10,RegWSrc=0 in one cycle.
//  MEM_TIMEOUT=4, MemReady=0 in FETCH -> MemErr=1 after 4 stalls, state IDLE, Retired unchanged.
//  Op 6'b111111 -> with ILLEGAL_TRAP_EN Illegal=1 stuck; without, Retired+1, back to FETCH;
//   rst_n low mid-MEM_WR -> MemWrite=0 immediately, Retired=0.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencer for the multi-cycle shared-memory datapath, with a retired-instruction counter and a memory stall watchdog.
// Optional ILLEGAL_TRAP_EN: an illegal instruction halts in ILLEGAL and drives an extra Illegal port until reset.
module multi_cycle_controller #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       OpCode,
   input  logic [5:0]       Func,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOperation,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic             RegWSrc,
   output logic             MemToReg,
   output logic [CNT_W-1:0] Retired,
   output logic             MemErr
`ifdef ILLEGAL_TRAP_EN
   ,output logic            Illegal
`endif
);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
      MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JR, JAL, ILLEGAL
   } state_t;

   // The counter only has to hold MEM_TIMEOUT-1: the stall that would reach
   // MEM_TIMEOUT triggers the abort instead of being counted.
   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              stall;
   logic              timeout;
   logic              retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         Retired  <= '0;
         MemErr   <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= (stall && !timeout) ? wait_cnt + 1'b1 : '0;
         if (retire)
            Retired <= Retired + 1'b1;
         if (timeout)
            MemErr <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      stall        = 1'b0;
      timeout      = 1'b0;
      retire       = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      PCSrc        = 2'b00;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOperation = 3'b000;
      RegWrite     = 1'b0;
      RegDst       = 2'b00;
      RegWSrc      = 1'b0;
      MemToReg     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      Illegal      = 1'b0;
`endif
      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (MemReady) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               state_next = DECODE;
            end else begin
               stall = 1'b1;
            end
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (OpCode)
               6'd0: begin
                  case (Func)
                     6'b000001, 6'b000010, 6'b000100,
                     6'b001000, 6'b010000: state_next = EXEC_R;
                     default:              state_next = ILLEGAL;
                  endcase
               end
               6'd1, 6'd2: state_next = EXEC_I;
               6'd3, 6'd4: state_next = MEM_ADDR;
               6'd5:       state_next = BRANCH;
               6'd6:       state_next = JUMP;
               6'd7:       state_next = JR;
               6'd8:       state_next = JAL;
               default:    state_next = ILLEGAL;
            endcase
         end
         EXEC_R: begin
            ALUSrcA = 1'b1;
            case (Func)
               6'b000010: ALUOperation = 3'b001;
               6'b000100: ALUOperation = 3'b010;
               6'b001000: ALUOperation = 3'b011;
               6'b010000: ALUOperation = 3'b100;
               default:   ALUOperation = 3'b000;
            endcase
            state_next = WB_R;
         end
         WB_R: begin
            RegWrite   = 1'b1;
            RegDst     = 2'b01;
            RegWSrc    = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         EXEC_I: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ALUOperation = (OpCode == 6'd2) ? 3'b100 : 3'b000;
            state_next   = WB_I;
         end
         WB_I: begin
            RegWrite   = 1'b1;
            RegWSrc    = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            state_next = (OpCode == 6'd4) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (MemReady)
               state_next = MEM_WB;
            else
               stall = 1'b1;
         end
         MEM_WB: begin
            RegWrite   = 1'b1;
            RegWSrc    = 1'b1;
            MemToReg   = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) begin
               retire     = 1'b1;
               state_next = FETCH;
            end else begin
               stall = 1'b1;
            end
         end
         BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUOperation = 3'b001;
            PCSrc        = 2'b01;
            PCWrite      = Zero;
            retire       = 1'b1;
            state_next   = FETCH;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            retire     = 1'b1;
            state_next = FETCH;
         end
         JR: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b11;
            retire     = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            RegWrite   = 1'b1;
            RegDst     = 2'b10;
            retire     = 1'b1;
            state_next = FETCH;
         end
         ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            Illegal    = 1'b1;
`else
            retire     = 1'b1;
            state_next = FETCH;
`endif
         end
         default: state_next = IDLE;
      endcase
      // Abandon the access on the stall that would reach MEM_TIMEOUT.
      if (stall && wait_cnt == WAIT_LAST) begin
         timeout    = 1'b1;
         state_next = IDLE;
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: walks instruction classes, stalls, timeout and reset cases.
// Control outputs are compared as one packed vector in the field order of the ctl wire below.
module tb_multi_cycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  OpCode;
   logic [5:0]  Func;
   logic        Zero;
   logic        MemReady;
   logic        IorD, MemRead, MemWrite, IRWrite, PCWrite;
   logic [1:0]  PCSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [2:0]  ALUOperation;
   logic        RegWrite;
   logic [1:0]  RegDst;
   logic        RegWSrc, MemToReg;
   logic [31:0] Retired;
   logic        MemErr;
`ifdef ILLEGAL_TRAP_EN
   logic        Illegal;
`endif

   int n_cmp = 0;
   int n_err = 0;

   multi_cycle_controller #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Func(Func), .Zero(Zero),
      .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation), .RegWrite(RegWrite),
      .RegDst(RegDst), .RegWSrc(RegWSrc), .MemToReg(MemToReg),
      .Retired(Retired), .MemErr(MemErr)
`ifdef ILLEGAL_TRAP_EN
      , .Illegal(Illegal)
`endif
   );

   always #5 clk = ~clk;

   // {IorD,MemRead,MemWrite,IRWrite,PCWrite}_PCSrc_ALUSrcA_ALUSrcB_ALUOp_RegWrite_RegDst_RegWSrc_MemToReg
   logic [17:0] ctl;
   assign ctl = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
                 ALUOperation, RegWrite, RegDst, RegWSrc, MemToReg};

   localparam logic [17:0] C_ZERO    = 18'b00000_00_0_00_000_0_00_0_0;
   localparam logic [17:0] C_FETCH   = 18'b01011_00_0_01_000_0_00_0_0;
   localparam logic [17:0] C_FSTALL  = 18'b01000_00_0_01_000_0_00_0_0;
   localparam logic [17:0] C_DECODE  = 18'b00000_00_0_11_000_0_00_0_0;
   localparam logic [17:0] C_EXR_ADD = 18'b00000_00_1_00_000_0_00_0_0;
   localparam logic [17:0] C_EXR_SUB = 18'b00000_00_1_00_001_0_00_0_0;
   localparam logic [17:0] C_WB_R    = 18'b00000_00_0_00_000_1_01_1_0;
   localparam logic [17:0] C_EXI_SLT = 18'b00000_00_1_10_100_0_00_0_0;
   localparam logic [17:0] C_WB_I    = 18'b00000_00_0_00_000_1_00_1_0;
   localparam logic [17:0] C_MADDR   = 18'b00000_00_1_10_000_0_00_0_0;
   localparam logic [17:0] C_MEM_RD  = 18'b11000_00_0_00_000_0_00_0_0;
   localparam logic [17:0] C_MEM_WB  = 18'b00000_00_0_00_000_1_00_1_1;
   localparam logic [17:0] C_MEM_WR  = 18'b10100_00_0_00_000_0_00_0_0;
   localparam logic [17:0] C_BEQ_T   = 18'b00001_01_1_00_001_0_00_0_0;
   localparam logic [17:0] C_BEQ_N   = 18'b00000_01_1_00_001_0_00_0_0;
   localparam logic [17:0] C_JUMP    = 18'b00001_10_0_00_000_0_00_0_0;
   localparam logic [17:0] C_JR      = 18'b00001_11_0_00_000_0_00_0_0;
   localparam logic [17:0] C_JAL     = 18'b00001_10_0_00_000_1_10_0_0;

   task automatic check_ctl(input string tag, input logic [17:0] exp);
      n_cmp++;
      assert (ctl === exp) else begin
         n_err++;
         $error("FAIL %s: ctl got %b want %b", tag, ctl, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Check the current state's outputs mid-cycle, then step to just after the next edge.
   task automatic cyc(input string tag, input logic [17:0] exp);
      @(negedge clk);
      check_ctl(tag, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; OpCode = '0; Func = '0; Zero = 1'b0; MemReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_ctl("reset_ctl", C_ZERO);
      check_val("reset_retired", Retired, 0);
      check_val("reset_memerr", MemErr, 0);
      rst_n = 1'b1;
      cyc("idle", C_ZERO);

      // add
      MemReady = 1'b1; OpCode = 6'd0; Func = 6'b000001;
      cyc("add_fetch", C_FETCH);
      cyc("add_decode", C_DECODE);
      cyc("add_exec", C_EXR_ADD);
      cyc("add_wb", C_WB_R);
      check_val("add_retired", Retired, 1);

      // sub
      Func = 6'b000010;
      cyc("sub_fetch", C_FETCH);
      cyc("sub_decode", C_DECODE);
      cyc("sub_exec", C_EXR_SUB);
      cyc("sub_wb", C_WB_R);
      check_val("sub_retired", Retired, 2);

      // slti
      OpCode = 6'd2;
      cyc("slti_fetch", C_FETCH);
      cyc("slti_decode", C_DECODE);
      cyc("slti_exec", C_EXI_SLT);
      cyc("slti_wb", C_WB_I);
      check_val("slti_retired", Retired, 3);

      // lw with three stalled cycles
      OpCode = 6'd3;
      cyc("lw_fetch", C_FETCH);
      cyc("lw_decode", C_DECODE);
      cyc("lw_addr", C_MADDR);
      MemReady = 1'b0;
      cyc("lw_rd_stall1", C_MEM_RD);
      cyc("lw_rd_stall2", C_MEM_RD);
      cyc("lw_rd_stall3", C_MEM_RD);
      MemReady = 1'b1;
      cyc("lw_rd_done", C_MEM_RD);
      cyc("lw_wb", C_MEM_WB);
      check_val("lw_retired", Retired, 4);
      check_val("lw_memerr", MemErr, 0);

      // sw with one stall
      OpCode = 6'd4;
      cyc("sw_fetch", C_FETCH);
      cyc("sw_decode", C_DECODE);
      cyc("sw_addr", C_MADDR);
      MemReady = 1'b0;
      cyc("sw_wr_stall", C_MEM_WR);
      check_val("sw_not_yet_retired", Retired, 4);
      MemReady = 1'b1;
      cyc("sw_wr_done", C_MEM_WR);
      check_val("sw_retired", Retired, 5);

      // beq taken / not taken
      OpCode = 6'd5; Zero = 1'b1;
      cyc("beq_t_fetch", C_FETCH);
      cyc("beq_t_decode", C_DECODE);
      cyc("beq_taken", C_BEQ_T);
      check_val("beq_t_retired", Retired, 6);
      Zero = 1'b0;
      cyc("beq_n_fetch", C_FETCH);
      cyc("beq_n_decode", C_DECODE);
      cyc("beq_not_taken", C_BEQ_N);
      check_val("beq_n_retired", Retired, 7);

      // jal, j, jr
      OpCode = 6'd8;
      cyc("jal_fetch", C_FETCH);
      cyc("jal_decode", C_DECODE);
      cyc("jal", C_JAL);
      check_val("jal_retired", Retired, 8);
      OpCode = 6'd6;
      cyc("j_fetch", C_FETCH);
      cyc("j_decode", C_DECODE);
      cyc("j", C_JUMP);
      OpCode = 6'd7;
      cyc("jr_fetch", C_FETCH);
      cyc("jr_decode", C_DECODE);
      cyc("jr", C_JR);
      check_val("jr_retired", Retired, 10);

      // fetch timeout after four stalls
      MemReady = 1'b0;
      cyc("to_stall1", C_FSTALL);
      cyc("to_stall2", C_FSTALL);
      cyc("to_stall3", C_FSTALL);
      check_val("to_memerr_early", MemErr, 0);
      cyc("to_stall4", C_FSTALL);
      check_val("to_memerr", MemErr, 1);
      check_val("to_retired", Retired, 10);
      MemReady = 1'b1;
      cyc("to_idle", C_ZERO);

      // illegal opcode
      OpCode = 6'b111111;
      cyc("ill_fetch", C_FETCH);
      cyc("ill_decode", C_DECODE);
`ifdef ILLEGAL_TRAP_EN
      cyc("ill_trap1", C_ZERO);
      check_val("ill_flag1", Illegal, 1);
      cyc("ill_trap2", C_ZERO);
      check_val("ill_flag2", Illegal, 1);
      check_val("ill_retired", Retired, 10);
      rst_n = 1'b0;
      #1;
      check_val("ill_flag_reset", Illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`else
      cyc("ill_nop", C_ZERO);
      check_val("ill_retired", Retired, 11);
      check_val("ill_memerr_sticky", MemErr, 1);
`endif

      // reset in the middle of a stalled store
      OpCode = 6'd4;
      cyc("rst_sw_fetch", C_FETCH);
      cyc("rst_sw_decode", C_DECODE);
      cyc("rst_sw_addr", C_MADDR);
      MemReady = 1'b0;
      cyc("rst_sw_wr", C_MEM_WR);
      #2;
      rst_n = 1'b0;
      #1;
      check_ctl("rst_mid_ctl", C_ZERO);
      check_val("rst_mid_retired", Retired, 0);
      check_val("rst_mid_memerr", MemErr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc("post_rst_fetch", C_FSTALL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
